// File: rtl/filter_bank_serializer_pkg.sv
// Shared definitions for the filter-bank serializer: sample/frame types,
// channel IDs, FSM states and channel-mask helpers.
package filt_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_LP = 2'd0;
  localparam logic [1:0] CH_HP = 2'd1;
  localparam logic [1:0] CH_BP = 2'd2;
  localparam logic [1:0] CH_MA = 2'd3;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [NUM_CH-1:0] frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Lowest enabled channel; 0 when no channel is enabled.
  function automatic logic [1:0] first_ch(input logic [3:0] mask);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Highest enabled channel; this beat carries out_last.
  function automatic logic [1:0] last_ch(input logic [3:0] mask);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Next enabled channel above cur; stays at cur if none is left.
  function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] ch;
    ch = cur;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) ch = 2'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/filter_bank_serializer_frame_fifo.sv
// Synchronous frame FIFO. Push and pop may happen together even when full:
// the write lands in the slot being popped, which is only overwritten at the
// clock edge that retires it.
module filter_bank_serializer_frame_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/filter_bank_serializer.sv
// Filter-bank serializer: captures LP/HP/BP/MA results as one frame per
// sample strobe, buffers frames, and emits them one channel per beat.
// Optional FILTER_BANK_CHAN_MASK_EN adds chan_mask to skip channels.
//
// Output handshake: a beat transfers on a cycle where out_valid && out_ready;
// once out_valid rises, out_valid/out_data/out_chan/out_last hold until that
// transfer.
module filter_bank_serializer #(
  parameter int DATA_W      = 16,
  parameter int FRAME_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] lp_in,
  input  logic signed [DATA_W-1:0] hp_in,
  input  logic signed [DATA_W-1:0] bp_in,
  input  logic signed [DATA_W-1:0] ma_in,
`ifdef FILTER_BANK_CHAN_MASK_EN
  input  logic [3:0]               chan_mask,
`endif
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [1:0]               out_chan,
  output logic                     out_last,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         frame_count
);

  import filt_pkg::*;

  localparam int CW = $clog2(FRAME_DEPTH) + 1;

  logic [NUM_CH-1:0][DATA_W-1:0] wframe;
  logic [NUM_CH-1:0][DATA_W-1:0] hframe;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] mask_now;
  logic [3:0] mask_q;

  logic is_send;
  logic no_beats;
  logic valid_i;
  logic is_last;
  logic beat;
  logic fire_last;
  logic pop;
  logic accept;
  logic drop;
  logic more;
  logic start;

  assign wframe = {ma_in, bp_in, hp_in, lp_in};

  filter_bank_serializer_frame_fifo #(
    .WIDTH (NUM_CH * DATA_W),
    .DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (wframe),
    .head  (hframe),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef FILTER_BANK_CHAN_MASK_EN
  assign mask_now = chan_mask;

  // Mask is latched as each frame's first beat is prepared.
  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else if (start) mask_q <= chan_mask;
  end
`else
  assign mask_now = 4'hF;
  assign mask_q   = 4'hF;
`endif

  assign is_send   = (state == SEND);
  assign no_beats  = (mask_q == 4'b0000);
  assign valid_i   = is_send && !no_beats;
  assign is_last   = (idx == last_ch(mask_q));
  assign beat      = valid_i && out_ready;
  assign fire_last = beat && is_last;
  // A fully masked frame is retired in one cycle without any beat.
  assign pop       = fire_last || (is_send && no_beats);
  // A popping head frees its slot for a strobe in the same cycle.
  assign accept    = sample_valid && (!fifo_full || pop);
  assign drop      = sample_valid && !accept;
  // FIFO still holds a frame after this cycle's pop and push.
  assign more      = (fifo_count > CW'(1)) || accept;
  assign start     = ((state == IDLE) && (!fifo_empty || accept)) || (pop && more);

  // Serializer FSM: walks the head frame channel by channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEND;
            idx   <= first_ch(mask_now);
          end
        end
        SEND: begin
          if (pop) begin
            if (more) begin
              idx <= first_ch(mask_now);
            end else begin
              state <= IDLE;
              idx   <= '0;
            end
          end else if (beat) begin
            idx <= next_ch(mask_q, idx);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Frame, drop and sticky overflow status.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
      if (fire_last) frame_count <= frame_count + CNT_W'(1);
    end
  end

  assign out_valid = valid_i;
  assign out_data  = valid_i ? hframe[idx] : '0;
  assign out_chan  = valid_i ? idx : 2'd0;
  assign out_last  = valid_i && is_last;

endmodule

// File: tb/tb_filter_bank_serializer.sv
// Directed bench for filter_bank_serializer. Define FILTER_BANK_CHAN_MASK_EN
// to also exercise the channel-mask feature.
module tb_filter_bank_serializer;

  localparam int DATA_W      = 16;
  localparam int FRAME_DEPTH = 2;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  logic rst;
  logic sample_valid;
  logic signed [DATA_W-1:0] lp_in, hp_in, bp_in, ma_in;
  logic out_ready;
  logic out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [1:0] out_chan;
  logic out_last;
  logic overflow;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] frame_count;
`ifdef FILTER_BANK_CHAN_MASK_EN
  logic [3:0] chan_mask;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [18:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  filter_bank_serializer #(
    .DATA_W      (DATA_W),
    .FRAME_DEPTH (FRAME_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .lp_in        (lp_in),
    .hp_in        (hp_in),
    .bp_in        (bp_in),
    .ma_in        (ma_in),
`ifdef FILTER_BANK_CHAN_MASK_EN
    .chan_mask    (chan_mask),
`endif
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_last     (out_last),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .frame_count  (frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [18:0] mk_beat(input logic lst, input logic [1:0] ch, input int data);
    logic [15:0] d;
    d = 16'(data);
    return {lst, ch, d};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_frame(input int lp, input int hp, input int bp, input int ma);
    sample_valid = 1'b1;
    lp_in = 16'(lp);
    hp_in = 16'(hp);
    bp_in = 16'(bp);
    ma_in = 16'(ma);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic expect_frame(input int lp, input int hp, input int bp, input int ma);
    exp_q.push_back(mk_beat(1'b0, 2'd0, lp));
    exp_q.push_back(mk_beat(1'b0, 2'd1, hp));
    exp_q.push_back(mk_beat(1'b0, 2'd2, bp));
    exp_q.push_back(mk_beat(1'b1, 2'd3, ma));
  endtask

  // Scoreboard: every accepted beat must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("spare beat", 32'(exp_q.size()), 32'd1);
      else check_eq("beat", {13'd0, out_last, out_chan, out_data}, {13'd0, exp_q.pop_front()});
    end
  end

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    lp_in = '0; hp_in = '0; bp_in = '0; ma_in = '0;
    out_ready = 1'b0;
`ifdef FILTER_BANK_CHAN_MASK_EN
    chan_mask = 4'hF;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_data", 32'(out_data), 32'd0);
    check_eq("rst out_chan", 32'(out_chan), 32'd0);
    check_eq("rst out_last", 32'(out_last), 32'd0);
    check_eq("rst overflow", 32'(overflow), 32'd0);
    check_eq("rst drop_count", 32'(drop_count), 32'd0);
    check_eq("rst frame_count", 32'(frame_count), 32'd0);

    // 1: single frame, first beat one cycle after the strobe
    out_ready = 1'b1;
    expect_frame(100, -200, 300, -400);
    send_frame(100, -200, 300, -400);
    check_eq("t1 first valid", 32'(out_valid), 32'd1);
    check_eq("t1 first chan", 32'(out_chan), 32'd0);
    check_eq("t1 first data", 32'(out_data), 32'd100);
    check_eq("t1 first last", 32'(out_last), 32'd0);
    tick(); tick(); tick();
    check_eq("t1 fourth chan", 32'(out_chan), 32'd3);
    check_eq("t1 fourth last", 32'(out_last), 32'd1);
    tick();
    check_eq("t1 idle valid", 32'(out_valid), 32'd0);
    check_eq("t1 frame_count", 32'(frame_count), 32'd1);

    // 2: backpressure on chan1 for three cycles
    expect_frame(100, -200, 300, -400);
    send_frame(100, -200, 300, -400);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t2 hold valid", 32'(out_valid), 32'd1);
      check_eq("t2 hold chan", 32'(out_chan), 32'd1);
      check_eq("t2 hold data", 32'(out_data), -32'sd200);
      tick();
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    check_eq("t2 idle valid", 32'(out_valid), 32'd0);
    check_eq("t2 frame_count", 32'(frame_count), 32'd2);

    // 3: overflow with FIFO full and downstream stalled
    do_reset();
    check_eq("t3 reset frame_count", 32'(frame_count), 32'd0);
    out_ready = 1'b0;
    expect_frame(1, -1, 101, -101);
    expect_frame(2, -2, 102, -102);
    send_frame(1, -1, 101, -101);
    send_frame(2, -2, 102, -102);
    send_frame(3, -3, 103, -103);
    check_eq("t3 overflow", 32'(overflow), 32'd1);
    check_eq("t3 drop_count", 32'(drop_count), 32'd1);
    check_eq("t3 head data", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check_eq("t3 idle valid", 32'(out_valid), 32'd0);
    check_eq("t3 frame_count", 32'(frame_count), 32'd2);
    check_eq("t3 overflow sticky", 32'(overflow), 32'd1);

    // 4: strobe on the last beat of a full FIFO
    do_reset();
    out_ready = 1'b0;
    expect_frame(11, 12, 13, 14);
    expect_frame(22, 23, 24, 25);
    expect_frame(33, 34, 35, 36);
    send_frame(11, 12, 13, 14);
    send_frame(22, 23, 24, 25);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check_eq("t4 last beat", 32'(out_last), 32'd1);
    check_eq("t4 last data", 32'(out_data), 32'd14);
    send_frame(33, 34, 35, 36);
    check_eq("t4 no bubble valid", 32'(out_valid), 32'd1);
    check_eq("t4 no bubble chan", 32'(out_chan), 32'd0);
    check_eq("t4 no bubble data", 32'(out_data), 32'd22);
    check_eq("t4 drop_count", 32'(drop_count), 32'd0);
    check_eq("t4 overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) tick();
    check_eq("t4 idle valid", 32'(out_valid), 32'd0);
    check_eq("t4 frame_count", 32'(frame_count), 32'd3);

    // 5: reset during the chan2 beat
    exp_q.push_back(mk_beat(1'b0, 2'd0, 5));
    exp_q.push_back(mk_beat(1'b0, 2'd1, 6));
    send_frame(5, 6, 7, 8);
    tick(); tick();
    check_eq("t5 pre-reset chan", 32'(out_chan), 32'd2);
    do_reset();
    check_eq("t5 valid", 32'(out_valid), 32'd0);
    check_eq("t5 frame_count", 32'(frame_count), 32'd0);
    check_eq("t5 drop_count", 32'(drop_count), 32'd0);
    check_eq("t5 overflow", 32'(overflow), 32'd0);
    expect_frame(9, 10, 11, 12);
    send_frame(9, 10, 11, 12);
    check_eq("t5 fresh chan", 32'(out_chan), 32'd0);
    check_eq("t5 fresh data", 32'(out_data), 32'd9);
    tick(); tick(); tick(); tick();
    check_eq("t5 frame_count", 32'(frame_count), 32'd1);

`ifdef FILTER_BANK_CHAN_MASK_EN
    // 6: channel mask 1010, then an all-zero mask
    chan_mask = 4'b1010;
    exp_q.push_back(mk_beat(1'b0, 2'd1, 22));
    exp_q.push_back(mk_beat(1'b1, 2'd3, 24));
    send_frame(21, 22, 23, 24);
    chan_mask = 4'hF;
    check_eq("t6 first chan", 32'(out_chan), 32'd1);
    check_eq("t6 first last", 32'(out_last), 32'd0);
    tick();
    check_eq("t6 second chan", 32'(out_chan), 32'd3);
    check_eq("t6 second last", 32'(out_last), 32'd1);
    tick();
    check_eq("t6 frame_count", 32'(frame_count), 32'd2);
    chan_mask = 4'b0000;
    send_frame(41, 42, 43, 44);
    chan_mask = 4'hF;
    check_eq("t6 zero mask valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("t6 zero mask valid2", 32'(out_valid), 32'd0);
    check_eq("t6 zero mask frame_count", 32'(frame_count), 32'd2);
    expect_frame(51, 52, 53, 54);
    send_frame(51, 52, 53, 54);
    check_eq("t6 after zero data", 32'(out_data), 32'd51);
    tick(); tick(); tick(); tick();
`endif

    // Final report
    check_eq("queue drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
